// File: rtl/lea_pkg.sv
// Shared definitions for the LEA load path: block geometry, steering codes
// and the load-controller state encoding.
package lea_pkg;

  localparam int LEA_NBYTES = 16;
  localparam int LEA_BYTE_W = 8;

  localparam logic SEL_KEY  = 1'b0;
  localparam logic SEL_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    RUN
  } lea_ld_state_t;

endpackage

// File: rtl/lea_load_ctrl.sv
// Steers an incoming byte stream into the key or data shift register, counts
// 16-byte blocks and kicks the LEA core once a data block sits behind a valid key.
module lea_load_ctrl
  import lea_pkg::*;
#(
  parameter int NBYTES = LEA_NBYTES,
  parameter int CW     = $clog2(NBYTES)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [LEA_BYTE_W-1:0] IN_DATA,
  input  logic                  IN_VALID,
  input  logic                  IN_SEL,
  output logic                  IN_READY,
  output logic [LEA_BYTE_W-1:0] SR_DIN,
  output logic                  KEY_CE,
  output logic                  DATA_CE,
  output logic                  CORE_START,
  input  logic                  CORE_DONE,
  output logic                  KEY_VALID,
  output logic [CW-1:0]         BYTE_CNT,
  output logic                  ERR,
  input  logic                  CLR
);

  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

  lea_ld_state_t state_q;
  logic          sel_q;
  logic          key_valid_q;
  logic          core_start_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;

  logic xfer;
  logic shift;
  logic cur_sel;

  assign IN_READY = (state_q == IDLE) || (state_q == LOAD);
  assign xfer     = IN_VALID & IN_READY;

  // Reset and soft abort both suppress the shift so a dropped byte never lands in a chain.
  assign shift    = xfer & RST & ~CLR;
  assign cur_sel  = (state_q == IDLE) ? IN_SEL : sel_q;
  assign KEY_CE   = shift & (cur_sel == SEL_KEY);
  assign DATA_CE  = shift & (cur_sel == SEL_DATA);
  assign SR_DIN   = IN_DATA;

  assign CORE_START = core_start_q;
  assign ERR        = err_q;
  assign KEY_VALID  = key_valid_q;
  assign BYTE_CNT   = cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= IDLE;
      sel_q        <= SEL_KEY;
      key_valid_q  <= 1'b0;
      core_start_q <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else if (CLR) begin
      state_q      <= IDLE;
      sel_q        <= SEL_KEY;
      key_valid_q  <= 1'b0;
      core_start_q <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      core_start_q <= 1'b0;
      err_q        <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            sel_q   <= IN_SEL;
            cnt_q   <= CW'(1);
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (xfer) begin
            if (cnt_q == LAST_IDX) begin
              cnt_q <= '0;
              if (sel_q == SEL_KEY) begin
                key_valid_q <= 1'b1;
                state_q     <= IDLE;
              end else if (key_valid_q) begin
                core_start_q <= 1'b1;
                state_q      <= START;
              end else begin
                // Data without a key is discarded; flag it and wait for a new block.
                err_q   <= 1'b1;
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        START: begin
          state_q <= RUN;
        end
        RUN: begin
          if (CORE_DONE) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lea_load_ctrl.sv
// Directed bench for lea_load_ctrl: a scoreboard of expected shift events plus
// checks on block counting, core start, error pulse, soft abort and reset.
module tb_lea_load_ctrl;
  import lea_pkg::*;

  typedef struct {
    logic       isData;
    logic [7:0] data;
  } shiftExpT;

  logic       clk;
  logic       rst;
  logic [7:0] inData;
  logic       inValid;
  logic       inSel;
  logic       inReady;
  logic [7:0] srDin;
  logic       keyCe;
  logic       dataCe;
  logic       coreStart;
  logic       coreDone;
  logic       keyValid;
  logic [3:0] byteCnt;
  logic       err;
  logic       clr;

  int checks = 0;
  int errors = 0;
  int startCount = 0;
  int errCount = 0;
  shiftExpT expQ[$];

  lea_load_ctrl #(.NBYTES(16), .CW(4)) dut (
    .CLK       (clk),
    .RST       (rst),
    .IN_DATA   (inData),
    .IN_VALID  (inValid),
    .IN_SEL    (inSel),
    .IN_READY  (inReady),
    .SR_DIN    (srDin),
    .KEY_CE    (keyCe),
    .DATA_CE   (dataCe),
    .CORE_START(coreStart),
    .CORE_DONE (coreDone),
    .KEY_VALID (keyValid),
    .BYTE_CNT  (byteCnt),
    .ERR       (err),
    .CLR       (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge; optionally record the shift it must cause.
  task automatic applyStimulus(input logic v, input logic s, input logic [7:0] d,
                               input logic pushExp, input logic expData);
    @(negedge clk);
    inValid = v;
    inSel   = s;
    inData  = d;
    if (pushExp) expQ.push_back('{isData: expData, data: d});
  endtask

  task automatic sendBytes(input logic isData, input logic [7:0] base, input int n, input logic toggleSel);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("byte_cnt", {28'd0, byteCnt}, i);
      checkOutput("in_ready", {31'd0, inReady}, 1);
      inValid = 1'b1;
      inSel   = (toggleSel && i > 0) ? ~isData : isData;
      inData  = base + 8'(i);
      expQ.push_back('{isData: isData, data: base + 8'(i)});
    end
  endtask

  task automatic sendBlock(input logic isData, input logic [7:0] base, input logic toggleSel);
    sendBytes(isData, base, 16, toggleSel);
    @(negedge clk);
    inValid = 1'b0;
  endtask

  // Scoreboard side: every shift enable seen just before a rising edge must match the queue head.
  always @(negedge clk) begin
    #4;
    if (coreStart) startCount++;
    if (err) errCount++;
    if (keyCe || dataCe) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL unexpected_ce: observed key=%0b data=%0b expected none", keyCe, dataCe);
      end else begin
        shiftExpT e;
        e = expQ.pop_front();
        checkOutput("sb_data_ce", {31'd0, dataCe}, {31'd0, e.isData});
        checkOutput("sb_key_ce", {31'd0, keyCe}, {31'd0, ~e.isData});
        checkOutput("sb_sr_din", {24'd0, srDin}, {24'd0, e.data});
      end
    end
  end

  initial begin
    rst = 1'b0; clr = 1'b0; coreDone = 1'b0;
    inValid = 1'b0; inSel = 1'b0; inData = 8'h00;

    // Reset: shift enables stay low even with a valid byte offered.
    applyStimulus(1'b1, SEL_KEY, 8'hEE, 1'b0, 1'b0);
    #1 checkOutput("rst_key_ce", {31'd0, keyCe}, 0);
    applyStimulus(1'b0, SEL_KEY, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", {31'd0, inReady}, 1);
    checkOutput("rst_key_valid", {31'd0, keyValid}, 0);
    checkOutput("rst_cnt", {28'd0, byteCnt}, 0);
    checkOutput("rst_start", {31'd0, coreStart}, 0);
    checkOutput("rst_err", {31'd0, err}, 0);

    // Key block 0x00..0x0F.
    sendBlock(SEL_KEY, 8'h00, 1'b0);
    checkOutput("key_valid_after_key", {31'd0, keyValid}, 1);
    checkOutput("cnt_after_key", {28'd0, byteCnt}, 0);
    checkOutput("no_start_after_key", startCount, 0);
    checkOutput("sb_empty_key", expQ.size(), 0);

    // Data block 0xA0..0xAF with IN_SEL dropped after the first byte.
    sendBlock(SEL_DATA, 8'hA0, 1'b1);
    checkOutput("start_pulse", {31'd0, coreStart}, 1);
    checkOutput("ready_in_start", {31'd0, inReady}, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, SEL_DATA, 8'h55, 1'b0, 1'b0);
      checkOutput("ready_in_run", {31'd0, inReady}, 0);
      checkOutput("start_low_run", {31'd0, coreStart}, 0);
    end
    applyStimulus(1'b0, SEL_DATA, 8'h00, 1'b0, 1'b0);
    coreDone = 1'b1;
    @(negedge clk);
    coreDone = 1'b0;
    checkOutput("ready_after_done", {31'd0, inReady}, 1);
    checkOutput("start_count_one", startCount, 1);
    checkOutput("key_retained", {31'd0, keyValid}, 1);

    // Data with no key after reset must raise ERR for a single cycle.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("key_valid_cleared", {31'd0, keyValid}, 0);
    sendBlock(SEL_DATA, 8'h10, 1'b0);
    checkOutput("err_pulse", {31'd0, err}, 1);
    checkOutput("ready_after_err", {31'd0, inReady}, 1);
    @(negedge clk);
    checkOutput("err_one_cycle", {31'd0, err}, 0);
    checkOutput("no_key_after_err", {31'd0, keyValid}, 0);
    checkOutput("no_start_on_err", startCount, 1);
    checkOutput("err_count", errCount, 1);

    // Gapped key block: counter moves only on handshakes.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checkOutput("gap_cnt", {28'd0, byteCnt}, ((i + 1) / 2) % 16);
      inValid = (i % 2 == 0);
      inSel   = SEL_KEY;
      inData  = 8'h30 + 8'(i / 2);
      if (i % 2 == 0) expQ.push_back('{isData: 1'b0, data: 8'h30 + 8'(i / 2)});
    end
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("gap_key_valid", {31'd0, keyValid}, 1);
    checkOutput("gap_cnt_wrap", {28'd0, byteCnt}, 0);

    // Soft abort after 7 key bytes overrides the simultaneous handshake.
    sendBytes(SEL_KEY, 8'h60, 7, 1'b0);
    applyStimulus(1'b1, SEL_KEY, 8'h77, 1'b0, 1'b0);
    clr = 1'b1;
    #1;
    checkOutput("clr_no_key_ce", {31'd0, keyCe}, 0);
    checkOutput("clr_no_data_ce", {31'd0, dataCe}, 0);
    @(negedge clk);
    clr = 1'b0;
    inValid = 1'b0;
    checkOutput("clr_cnt", {28'd0, byteCnt}, 0);
    checkOutput("clr_key_valid", {31'd0, keyValid}, 0);
    sendBlock(SEL_KEY, 8'h40, 1'b0);
    checkOutput("key_after_clr", {31'd0, keyValid}, 1);

    // Reset after 9 data bytes discards them; the next 16 form a fresh block.
    sendBytes(SEL_DATA, 8'h80, 9, 1'b0);
    applyStimulus(1'b1, SEL_DATA, 8'h99, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_no_ce", {31'd0, dataCe}, 0);
    @(negedge clk);
    rst = 1'b1;
    inValid = 1'b0;
    checkOutput("rst_mid_cnt", {28'd0, byteCnt}, 0);
    checkOutput("rst_mid_key_valid", {31'd0, keyValid}, 0);
    sendBlock(SEL_DATA, 8'hC0, 1'b0);
    checkOutput("fresh_block_err", {31'd0, err}, 1);
    checkOutput("fresh_block_no_start", {31'd0, coreStart}, 0);

    @(negedge clk);
    checkOutput("sb_empty_end", expQ.size(), 0);
    checkOutput("start_count_end", startCount, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lea_load_ctrl.md
# lea_load_ctrl

Byte-stream load sequencer for the LEA block. It accepts 8-bit bytes over a valid/ready handshake and steers each one into the key shift register or the data shift register (16 × 8-bit chains) by driving their shift enables. It counts complete 16-byte blocks, tracks key validity, and starts the LEA core once a full data block sits behind a valid key. It holds off new input until the core reports completion.

## Interface
Parameters:
- NBYTES, 16: bytes per block (shift-register depth).
- CW, 4: byte-counter width, equal to clog2(NBYTES).

Ports:
- CLK  in  1  clock. All logic is rising-edge.
- RST  in  1  reset; synchronous and active-low.
- IN_DATA  in  8  input byte.
- IN_VALID  in  1  IN_DATA is valid.
- IN_SEL  in  1  block type: 0 = key, 1 = data. Sampled only on the first byte of a block.
- IN_READY  out  1  controller can accept a byte.
- SR_DIN  out  8  byte to both shift registers; equals IN_DATA.
- KEY_CE  out  1  shift enable, key register.
- DATA_CE  out  1  shift enable, data register.
- CORE_START  out  1  one-cycle start pulse to the LEA core.
- CORE_DONE  in  1  one-cycle completion pulse from the core.
- KEY_VALID  out  1  a complete key block is loaded.
- BYTE_CNT  out  CW  bytes accepted in the current block.
- ERR  out  1  one-cycle pulse: a data block completed with no valid key.
- CLR  in  1  synchronous soft abort, active-high.

## Operation
- States: IDLE, LOAD, START, RUN.
- Transfer condition: xfer = IN_VALID & IN_READY.
- IN_READY = 1 in IDLE and LOAD; 0 in START and RUN.
- KEY_CE = xfer & ~cur_sel. DATA_CE = xfer & cur_sel.
  - In IDLE, cur_sel = IN_SEL.
  - In LOAD, cur_sel = the registered sel_q.
  - CE is combinational, so the shift register captures IN_DATA on the same edge as the handshake.
- IDLE, on xfer: sel_q <= IN_SEL; BYTE_CNT <= 1; go to LOAD.
- LOAD, on xfer with BYTE_CNT < NBYTES-1: BYTE_CNT increments. IN_SEL is ignored.
- LOAD, on xfer with BYTE_CNT == NBYTES-1 (final byte): BYTE_CNT <= 0, then one of:
  - sel_q = 0: KEY_VALID <= 1; go to IDLE.
  - sel_q = 1 and KEY_VALID = 1: go to START.
  - sel_q = 1 and KEY_VALID = 0: ERR pulses in the next cycle; go to IDLE. The data is left unused.
- START: CORE_START = 1 for exactly one cycle; go to RUN.
- RUN: wait for CORE_DONE, then go to IDLE. KEY_VALID is retained, so further data blocks reuse the key.
- Key reload: a new key block overwrites the key chain and sets KEY_VALID again. KEY_VALID stays 1 while the new key loads; the core is idle at that point by construction.
- CLR: in any state, next state is IDLE, BYTE_CNT <= 0 and KEY_VALID <= 0. It overrides a simultaneous xfer: no CE is asserted that cycle and no ERR is raised. A CORE_DONE arriving later is ignored.
- CORE_DONE outside RUN is ignored.
- Counter wrap: BYTE_CNT never reaches NBYTES. It returns to 0 on block completion.

## Timing
- Reset (RST = 0 at a CLK edge): state = IDLE, BYTE_CNT = 0, KEY_VALID = 0, sel_q = 0, CORE_START = 0, ERR = 0.
  - IN_READY is 1 from the first cycle after reset.
  - CE outputs are 0 while RST = 0 (gated by reset).
- Reset mid-block discards the partial block. The next byte starts a new block.
- Throughput: 1 byte per cycle while IN_VALID is held.
- The first byte of the next block may be accepted in the cycle after a key block's final byte.
- Data block latency: final-byte edge → START state → CORE_START high for one cycle. The pulse appears 1 cycle after the final byte is accepted.
- IN_READY falls in the same cycle CORE_START rises. It returns in the cycle after CORE_DONE is sampled.
- ERR is registered: high in the cycle after the final data byte, for one cycle.
- KEY_VALID rises in the cycle after the final key byte.

## Structure
- Shared package lea_pkg holds:
  - LEA_NBYTES = 16 and LEA_BYTE_W = 8.
  - The state enum lea_ld_state_t {IDLE, LOAD, START, RUN}.
  - SEL_KEY = 0, SEL_DATA = 1.
- Single module; no sub-module needed. The shift registers are instantiated by the parent alongside this controller.

## Test plan
- Reset, then 16 key bytes 0x00..0x0F with IN_VALID held → KEY_CE high for exactly 16 cycles, KEY_VALID = 1 in cycle 17, BYTE_CNT back to 0, no CORE_START.
- After the key, 16 data bytes 0xA0..0xAF → DATA_CE high 16 cycles; CORE_START is one cycle, the cycle after byte 16; IN_READY = 0 until CORE_DONE is pulsed 20 cycles later, then 1 the next cycle.
- From reset, 16 data bytes with no key → ERR pulses one cycle after byte 16, no CORE_START, state returns to IDLE, KEY_VALID stays 0.
- Data block with IN_SEL toggled to 0 on bytes 2..16 → all 16 bytes steered via DATA_CE (SEL latched on byte 1).
- Gapped input (IN_VALID toggling 1/0) → BYTE_CNT advances only on xfer, and the block completes after exactly 16 handshakes.
- CLR asserted after 7 key bytes, and RST = 0 after 9 data bytes → BYTE_CNT = 0, KEY_VALID = 0, no CE that cycle; the next 16 bytes form a complete new block.
